joypad_port: RTL and testbench

- CPU-bus responder for the two standard controller ports.
- Consumes the cpu_2a03 strobes naddr4016r, naddr4017r and addr4016w, plus parallel button states from two controllers.
- Returns the serial button bits on the CPU data bus.
- Models two 4021-style 8-bit parallel-in/serial-out shift registers together with their latch and clock logic.

---
 rtl/joypad_port_pkg.sv | 21 ++
 rtl/joypad_shift.sv | 66 ++++++
 rtl/joypad_port.sv | 62 ++++++
 tb/tb_joypad_port.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/joypad_port_pkg.sv
// Shared constants for the controller port block.
//   btn_idx_e        : bit positions of each button in the parallel button word
//   OPEN_BUS_DEFAULT : default value for data_out[7:5] during a port read.
//                      A read of $4016/$4017 leaves the upper address byte ($40)
//                      on these bits, so the default is 3'b010.
package joypad_port_pkg;

    typedef enum int unsigned {
        BTN_A      = 0,
        BTN_B      = 1,
        BTN_SELECT = 2,
        BTN_START  = 3,
        BTN_UP     = 4,
        BTN_DOWN   = 5,
        BTN_LEFT   = 6,
        BTN_RIGHT  = 7
    } btn_idx_e;

    localparam logic [2:0] OPEN_BUS_DEFAULT = 3'b010;

endpackage

// File: rtl/joypad_shift.sv
// One controller port. This models a 4021-style 8-bit parallel-in/serial-out
// shift register, together with its button synchronizer, its read-strobe
// edge detect and its load/shift priority logic.
//   clock, nreset : system clock and asynchronous active-low reset
//   strobe        : controller latch level. While it is high the register
//                   reloads on every cycle.
//   rd_n          : active-low read strobe for this port
//   buttons       : raw parallel button states, active-high
//   ser_bit       : serial bit currently presented to the CPU
module joypad_shift
    import joypad_port_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       strobe,
    input  logic       rd_n,
    input  logic [7:0] buttons,
    output logic       ser_bit
);

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]                  shift_q, shift_d;
    logic                        prev_rd_n_q, prev_rd_n_d;
    logic [7:0]                  btn_sync;
    logic                        shift_evt;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // The access ends when the strobe returns high. Triggering the shift on
    // this edge gives one shift per access, however long the read lasts.
    assign shift_evt = ~prev_rd_n_q & rd_n;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = buttons;
        for (int i = 1; i < SYNC_STAGES; i++)
            sync_d[i] = sync_q[i-1];

        prev_rd_n_d = rd_n;

        // When the latch and a shift arrive together, the latch wins.
        shift_d = shift_q;
        if (strobe)
            shift_d = btn_sync;
        else if (shift_evt)
            shift_d = {1'b1, shift_q[7:1]};
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sync_q      <= '0;
            shift_q     <= 8'hFF;
            prev_rd_n_q <= 1'b1;
        end else begin
            sync_q      <= sync_d;
            shift_q     <= shift_d;
            prev_rd_n_q <= prev_rd_n_d;
        end
    end

    // While latched, the 4021 output follows the live A button.
    assign ser_bit = strobe ? btn_sync[BTN_A] : shift_q[0];

endmodule

// File: rtl/joypad_port.sv
// CPU-bus responder for the two standard controller ports.
//   clock, nreset            : system clock, asynchronous active-low reset
//   naddr4016r / naddr4017r  : active-low read strobes for port 1 / port 2
//   addr4016w[2:0]           : latched $4016 write bits. Only bit0 (the strobe)
//                              is used.
//   buttons_p1 / buttons_p2  : parallel button states, active-high
//   data_out[7:0], data_oe   : read data to the CPU, and its valid flag
module joypad_port
    import joypad_port_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] OPEN_BUS    = OPEN_BUS_DEFAULT
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       naddr4016r,
    input  logic       naddr4017r,
    input  logic [2:0] addr4016w,
    input  logic [7:0] buttons_p1,
    input  logic [7:0] buttons_p2,
    output logic [7:0] data_out,
    output logic       data_oe
);

    logic ser_p1, ser_p2;
    logic unused_wr_bits;

    // Bits 2:1 of the $4016 write have no function on the standard ports.
    assign unused_wr_bits = ^addr4016w[2:1];

    joypad_shift #(.SYNC_STAGES(SYNC_STAGES)) u_port1 (
        .clock   (clock),
        .nreset  (nreset),
        .strobe  (addr4016w[0]),
        .rd_n    (naddr4016r),
        .buttons (buttons_p1),
        .ser_bit (ser_p1)
    );

    joypad_shift #(.SYNC_STAGES(SYNC_STAGES)) u_port2 (
        .clock   (clock),
        .nreset  (nreset),
        .strobe  (addr4016w[0]),
        .rd_n    (naddr4017r),
        .buttons (buttons_p2),
        .ser_bit (ser_p2)
    );

    // When both strobes are low, port 1 takes priority.
    always_comb begin
        data_out = 8'h00;
        data_oe  = 1'b0;
        if (!naddr4016r) begin
            data_out = {OPEN_BUS, 4'b0000, ser_p1};
            data_oe  = 1'b1;
        end else if (!naddr4017r) begin
            data_out = {OPEN_BUS, 4'b0000, ser_p2};
            data_oe  = 1'b1;
        end
    end

endmodule

// File: tb/tb_joypad_port.sv
module tb_joypad_port;

    logic       clock = 1'b0;
    logic       nreset;
    logic       naddr4016r, naddr4017r;
    logic [2:0] addr4016w;
    logic [7:0] buttons_p1, buttons_p2;
    logic [7:0] data_out;
    logic       data_oe;

    int checks   = 0;
    int failures = 0;

    joypad_port dut (
        .clock      (clock),
        .nreset     (nreset),
        .naddr4016r (naddr4016r),
        .naddr4017r (naddr4017r),
        .addr4016w  (addr4016w),
        .buttons_p1 (buttons_p1),
        .buttons_p2 (buttons_p2),
        .data_out   (data_out),
        .data_oe    (data_oe)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // This is a one-cycle access on a port (1 or 2). The task checks data_out
    // while the strobe is low. The strobe then rises, which ends the access.
    task automatic rd(input int port, input string tag, input logic [7:0] exp);
        if (port == 1) naddr4016r = 1'b0; else naddr4017r = 1'b0;
        #1;
        chk(tag, data_out, exp);
        step();
        naddr4016r = 1'b1;
        naddr4017r = 1'b1;
        step();
    endtask

    task automatic latch();
        addr4016w = 3'b001;
        repeat (4) step();
        addr4016w = 3'b000;
        step();
    endtask

    initial begin
        logic [7:0] seq;
        nreset = 1'b0; naddr4016r = 1'b1; naddr4017r = 1'b1;
        addr4016w = 3'b000; buttons_p1 = 8'h00; buttons_p2 = 8'h00;
        repeat (3) step();
        nreset = 1'b1;
        step();

        // Reset state, and a read with the register still all ones
        chk("idle_data", data_out, 8'h00);
        chk("idle_oe", {7'd0, data_oe}, 8'h00);
        naddr4016r = 1'b0; #1;
        chk("rst_read_oe", {7'd0, data_oe}, 8'h01);
        step(); naddr4016r = 1'b1; step();
        rd(1, "rst_after", 8'h41);

        // Latch, then read out serially, including the exhaustion reads
        buttons_p1 = 8'b1000_0101;
        latch();
        seq = 8'b1000_0101;
        for (int i = 0; i < 8; i++)
            rd(1, $sformatf("serial%0d", i), {7'b0100000, seq[i]});
        rd(1, "exhaust8", 8'h41);
        rd(1, "exhaust9", 8'h41);

        // Long access: one shift only
        buttons_p1 = 8'h02;
        latch();
        naddr4016r = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1; chk($sformatf("long_c%0d", i), data_out, 8'h40);
            step();
        end
        naddr4016r = 1'b1; step();
        rd(1, "long_next", 8'h41);
        rd(1, "long_third", 8'h40);

        // Strobe held high: the output tracks A after the sync delay
        buttons_p1 = 8'h00;
        addr4016w = 3'b001;
        repeat (4) step();
        rd(1, "strb_a0", 8'h40);
        buttons_p1 = 8'h01;
        naddr4016r = 1'b0; #1;
        chk("strb_lag0", data_out, 8'h40);
        step(); #1;
        chk("strb_lag1", data_out, 8'h40);
        step(); #1;
        chk("strb_lag2", data_out, 8'h41);
        naddr4016r = 1'b1; step();
        rd(1, "strb_again", 8'h41);
        addr4016w = 3'b000; step();
        rd(1, "strb_rel0", 8'h41);
        rd(1, "strb_rel1", 8'h40);

        // Port independence and port priority
        buttons_p1 = 8'hFF; buttons_p2 = 8'h00;
        latch();
        rd(2, "p2_r0", 8'h40);
        rd(2, "p2_r1", 8'h40);
        rd(2, "p2_r2", 8'h40);
        rd(1, "p1_after_p2", 8'h41);
        naddr4016r = 1'b0; naddr4017r = 1'b0; #1;
        chk("prio_both", data_out, 8'h41);
        step(); naddr4016r = 1'b1; naddr4017r = 1'b1; step();

        // Reset in the middle of a sequence
        buttons_p1 = 8'h00;
        latch();
        rd(1, "mid_r0", 8'h40);
        rd(1, "mid_r1", 8'h40);
        rd(1, "mid_r2", 8'h40);
        #2 nreset = 1'b0; #1;
        chk("rst_async_idle", data_out, 8'h00);
        step(); nreset = 1'b1; step();
        rd(1, "post_rst0", 8'h41);
        rd(1, "post_rst1", 8'h41);
        rd(1, "post_rst2", 8'h41);
        chk("end_oe", {7'd0, data_oe}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
